cam_soc_sysid_regs: RTL
=======================

// Module: cam_soc_sysid_regs
// PURPOSE
//  Parametrised system-ID/build-info slave on the Avalon-MM control bus of cam_soc.
//  Returns the ID and build timestamp, plus two user info words.
//  Also provides a 64-bit uptime counter with coherent high-word snapshot,
//  a read/write scratch register and a control register.
//  Fixed-latency pipelined reads (readdatavalid); software probes the SoC and measures run time.
// PARAMETERS
//  ID_VALUE      32'h0000_0000  system ID returned at word 0
//  TIMESTAMP     32'd0          build timestamp returned at word 1
//  USER_WORD0    32'h0          constant returned at word 6
//  USER_WORD1    32'h0          constant returned at word 7
//  READ_LATENCY  1              cycles from read accept to readdatavalid; legal 1..3
//  SCRATCH_RST   32'h0          scratch register reset value
// PORTS
//  clock          in   1   single system clock, all logic rising-edge
//  reset          in   1   synchronous, active-high reset
//  address        in   3   Avalon word address
//  read           in   1   read request, accepted every cycle (no waitrequest)
//  write          in   1   write request, accepted every cycle
//  writedata      in   32  write data
//  byteenable     in   4   byte lanes for write
//  count_en       in   1   uptime increment strobe (e.g. 1 us tick)
//  readdata       out  32  read data, valid when readdatavalid=1
//  readdatavalid  out  1   one-cycle pulse per accepted read
// BEHAVIOUR
//  Map (word addr): 0 ID_VALUE(RO); 1 TIMESTAMP(RO); 2 UPTIME_LO(RO); 3 UPTIME_HI_SNAP(RO);
//   4 SCRATCH(RW, byteenable honoured); 5 CTRL(RW): bit0 FREEZE, bit1 CLEAR(write-1, self-clear, reads 0),
//   bits31:2 read 0; 6 USER_WORD0(RO); 7 USER_WORD1(RO).
//  Writes to RO words are ignored silently.
//  Reset: readdata=0, readdatavalid=0, uptime=0, snapshot=0, SCRATCH=SCRATCH_RST, FREEZE=0; read pipe flushed.
//  Read pipe: data mux sampled in accept cycle T, shifted through READ_LATENCY registers.
//   readdata/readdatavalid appear in cycle T+READ_LATENCY.
//   Back-to-back reads give back-to-back valids, in order.
//   readdata holds its last value when readdatavalid=0.
//  Uptime: 64-bit counter.
//   Increments by 1 on clock edges with count_en=1 and FREEZE=0.
//   Wraps 2^64-1 -> 0 with no flag.
//  Snapshot: accepted read of word 2 returns counter[31:0] as registered in cycle T (pre-increment)
//   and loads snapshot <= counter[63:32] from the same cycle.
//   Word 3 returns snapshot only and never live counter bits.
//  CLEAR: write CTRL with bit1=1 zeroes the counter at that edge; counter is 0 the next cycle.
//   CLEAR beats count_en in the same cycle; snapshot is unaffected.
//  FREEZE and CLEAR in one write: counter cleared and held at 0.
//  Simultaneous read+write, same or different word: write lands at edge T;
//   read returns pre-write value (mux sampled before edge).
//  Reset asserted mid-read: in-flight valids are discarded; no readdatavalid pulse until a new read.
//  Width rules: all registers 32 bits; byteenable=0 write is a no-op; address fully decoded (3 bits).
// TESTING
//  1 Reset, then reads of words 0,1,6,7 with ID_VALUE=32'h5716_ABCD, READ_LATENCY=2
//    -> values match params; each valid arrives exactly 2 cycles after its read.
//  2 count_en=1 continuous, force counter to 64'h0000_0001_FFFF_FFFF, read word 2 then word 3
//    -> lo=32'hFFFF_FFFF, hi=32'h1, even though the counter carried into hi during the pipeline.
//  3 Counter at 64'hFFFF_FFFF_FFFF_FFFF, count_en pulse -> lo=0 and hi snapshot=0 on next read pair.
//  4 Write SCRATCH 32'h1234_5678 with be=4'b0101 over SCRATCH_RST=0 -> reads 32'h0034_0078;
//    write to word 0 -> word 0 unchanged.
//  5 CTRL=32'h1 (FREEZE), 100 count_en pulses -> uptime unchanged;
//    CTRL=32'h2 together with count_en -> uptime reads 0; CTRL reads 0.
//  6 4 back-to-back reads, reset asserted the cycle after the 2nd read
//    -> readdatavalid=0 from the reset cycle onward; no stale pulses after reset drops.

Source files
------------

// File: rtl/cam_soc_sysid_regs.sv
// cam_soc_sysid_regs
// System-ID / build-info slave on the cam_soc Avalon-MM control bus.
// Provides constant ID/timestamp/user words, a 64-bit uptime counter with a
// coherent high-word snapshot, a byte-writable scratch register and a
// FREEZE/CLEAR control register. Reads have fixed, pipelined latency.
module cam_soc_sysid_regs #(
  parameter logic [31:0] ID_VALUE     = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'd0,
  parameter logic [31:0] USER_WORD0   = 32'h0,
  parameter logic [31:0] USER_WORD1   = 32'h0,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] SCRATCH_RST  = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  input  logic        count_en,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam logic [2:0] A_ID      = 3'd0;
  localparam logic [2:0] A_TS      = 3'd1;
  localparam logic [2:0] A_UP_LO   = 3'd2;
  localparam logic [2:0] A_UP_HI   = 3'd3;
  localparam logic [2:0] A_SCRATCH = 3'd4;
  localparam logic [2:0] A_CTRL    = 3'd5;
  localparam logic [2:0] A_USER0   = 3'd6;
  localparam logic [2:0] A_USER1   = 3'd7;

  logic [63:0] r_uptime;
  logic [31:0] r_snap;
  logic [31:0] r_scratch;
  logic        r_freeze;

  // Read pipe: stage 1 captures the mux in the accept cycle, the last stage
  // drives the outputs. Data stages only load behind a valid so the output
  // holds its last returned word between reads.
  logic [READ_LATENCY:1]       r_vld_pipe;
  logic [READ_LATENCY:1][31:0] r_dat_pipe;

  logic [31:0] w_rd_mux;
  logic        w_ctrl_wr;
  logic        w_clear;
  logic        w_scr_wr;
  logic        w_snap_ld;

  // CTRL only lives in byte lane 0; a write without lane 0 does nothing to it.
  assign w_ctrl_wr = write && (address == A_CTRL) && byteenable[0];
  assign w_clear   = w_ctrl_wr && writedata[1];
  assign w_scr_wr  = write && (address == A_SCRATCH);
  assign w_snap_ld = read && (address == A_UP_LO);

  // Read data mux, evaluated on pre-edge register state.
  always_comb begin
    w_rd_mux = 32'h0;
    case (address)
      A_ID:      w_rd_mux = ID_VALUE;
      A_TS:      w_rd_mux = TIMESTAMP;
      A_UP_LO:   w_rd_mux = r_uptime[31:0];
      A_UP_HI:   w_rd_mux = r_snap;
      A_SCRATCH: w_rd_mux = r_scratch;
      A_CTRL:    w_rd_mux = {31'h0, r_freeze};
      A_USER0:   w_rd_mux = USER_WORD0;
      A_USER1:   w_rd_mux = USER_WORD1;
      default:   w_rd_mux = 32'h0;
    endcase
  end

  // Uptime counter: CLEAR wins over counting; FREEZE is the pre-write value.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_uptime <= 64'h0;
    end else if (w_clear) begin
      r_uptime <= 64'h0;
    end else if (count_en && !r_freeze) begin
      r_uptime <= r_uptime + 64'd1;
    end
  end

  // High-word snapshot taken alongside every low-word read.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_snap <= 32'h0;
    end else if (w_snap_ld) begin
      r_snap <= r_uptime[63:32];
    end
  end

  // FREEZE bit; CLEAR is a pulse and is not stored.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_freeze <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_freeze <= writedata[0];
    end
  end

  // Scratch register with per-byte write enables.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_scratch <= SCRATCH_RST;
    end else if (w_scr_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b]) r_scratch[8*b +: 8] <= writedata[8*b +: 8];
      end
    end
  end

  // Fixed-latency read pipe; reset flushes every in-flight read.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_vld_pipe <= '0;
      r_dat_pipe <= '0;
    end else begin
      r_vld_pipe[1] <= read;
      if (read) r_dat_pipe[1] <= w_rd_mux;
      for (int k = 2; k <= READ_LATENCY; k++) begin
        r_vld_pipe[k] <= r_vld_pipe[k-1];
        if (r_vld_pipe[k-1]) r_dat_pipe[k] <= r_dat_pipe[k-1];
      end
    end
  end

  // A valid already in the last stage is suppressed while reset is high so
  // nothing is reported from the reset cycle onward.
  assign readdata      = r_dat_pipe[READ_LATENCY];
  assign readdatavalid = r_vld_pipe[READ_LATENCY] && !reset;

endmodule
